// File: rtl/vga_timing_gen_pkg.sv
// rtl/vga_timing_gen_pkg.sv - 640x480 timing constants, total helpers and coordinate width
package vga_timing_gen_pkg;

   localparam int COORD_W      = 10;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;

   function automatic int h_total(input int active, input int fp, input int sync, input int bp);
      return active + fp + sync + bp;
   endfunction

   function automatic int v_total(input int active, input int fp, input int sync, input int bp);
      return active + fp + sync + bp;
   endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - Raster output bundle; frame_cnt exists only with VGA_FRAME_CNT_EN
interface vga_timing_gen_if;
   import vga_timing_gen_pkg::*;

   logic               pix_tick;
   logic [COORD_W-1:0] x;
   logic [COORD_W-1:0] y;
   logic               video_on;
   logic               hsync;
   logic               vsync;
   logic               frame_start;
`ifdef VGA_FRAME_CNT_EN
   logic [15:0]        frame_cnt;

   modport master (output pix_tick, x, y, video_on, hsync, vsync, frame_start, frame_cnt);
   modport slave  (input  pix_tick, x, y, video_on, hsync, vsync, frame_start, frame_cnt);
`else
   modport master (output pix_tick, x, y, video_on, hsync, vsync, frame_start);
   modport slave  (input  pix_tick, x, y, video_on, hsync, vsync, frame_start);
`endif

endinterface

// File: rtl/vga_timing_gen_pixel_clk_div.sv
// rtl/vga_timing_gen_pixel_clk_div.sv - Pixel-rate divider producing one tick every CLK_DIV enabled clocks
module vga_timing_gen_pixel_clk_div #(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic restart,
   output logic tick
);

   localparam int             DW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0]  LAST = DW'(CLK_DIV - 1);

   logic [DW-1:0] div_cnt;

   // restart suppresses the tick so the counters see only the restart at that edge
   assign tick = en && !restart && (div_cnt == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt <= '0;
      end else if (restart) begin
         div_cnt <= '0;
      end else if (en) begin
         div_cnt <= (div_cnt == LAST) ? '0 : div_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator; VGA_FRAME_CNT_EN adds the 16-bit frame counter
module vga_timing_gen
   import vga_timing_gen_pkg::*;
#(
   parameter int   H_ACTIVE = DEF_H_ACTIVE,
   parameter int   H_FP     = DEF_H_FP,
   parameter int   H_SYNC   = DEF_H_SYNC,
   parameter int   H_BP     = DEF_H_BP,
   parameter int   V_ACTIVE = DEF_V_ACTIVE,
   parameter int   V_FP     = DEF_V_FP,
   parameter int   V_SYNC   = DEF_V_SYNC,
   parameter int   V_BP     = DEF_V_BP,
   parameter int   CLK_DIV  = 2,
   parameter logic HS_POL   = 1'b0,
   parameter logic VS_POL   = 1'b0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              restart,
   vga_timing_gen_if.master  vga
);

   localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

   localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
   localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
   localparam logic [COORD_W-1:0] H_ACT_C  = COORD_W'(H_ACTIVE);
   localparam logic [COORD_W-1:0] V_ACT_C  = COORD_W'(V_ACTIVE);
   localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_ACTIVE + H_FP);
   localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_ACTIVE + V_FP);
   localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

   logic               tick;
   logic [COORD_W-1:0] h_cnt;
   logic [COORD_W-1:0] v_cnt;
   logic [COORD_W-1:0] h_nxt;
   logic [COORD_W-1:0] v_nxt;
   logic               h_wrap;
   logic               v_wrap;

   vga_timing_gen_pixel_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .restart (restart),
      .tick    (tick)
   );

   always_comb begin
      h_wrap = (h_cnt == H_LAST);
      v_wrap = h_wrap && (v_cnt == V_LAST);
      h_nxt  = h_wrap ? '0 : h_cnt + 1'b1;
      v_nxt  = v_cnt;
      if (h_wrap) begin
         v_nxt = v_wrap ? '0 : v_cnt + 1'b1;
      end
   end

   // The counters are registered and double as the x/y outputs
   assign vga.x = h_cnt;
   assign vga.y = v_cnt;

   // Decodes use the post-update counters so pix_tick lines up with the new x/y
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_cnt           <= '0;
         v_cnt           <= '0;
         vga.pix_tick    <= 1'b0;
         vga.frame_start <= 1'b0;
         vga.video_on    <= 1'b0;
         vga.hsync       <= ~HS_POL;
         vga.vsync       <= ~VS_POL;
      end else if (restart) begin
         h_cnt           <= '0;
         v_cnt           <= '0;
         vga.pix_tick    <= 1'b1;
         vga.frame_start <= 1'b1;
         vga.video_on    <= 1'b0;
         vga.hsync       <= ~HS_POL;
         vga.vsync       <= ~VS_POL;
      end else begin
         vga.pix_tick    <= tick;
         vga.frame_start <= tick && v_wrap;
         if (tick) begin
            h_cnt        <= h_nxt;
            v_cnt        <= v_nxt;
            vga.video_on <= (h_nxt < H_ACT_C) && (v_nxt < V_ACT_C);
            vga.hsync    <= ((h_nxt >= HS_START) && (h_nxt < HS_END)) ? HS_POL : ~HS_POL;
            vga.vsync    <= ((v_nxt >= VS_START) && (v_nxt < VS_END)) ? VS_POL : ~VS_POL;
         end
      end
   end

`ifdef VGA_FRAME_CNT_EN
   logic [15:0] frame_cnt_q;

   assign vga.frame_cnt = frame_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_cnt_q <= '0;
      end else if (restart) begin
         frame_cnt_q <= '0;
      end else if (tick && v_wrap) begin
         frame_cnt_q <= frame_cnt_q + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - Self-checking bench: default-timing line checks plus a reduced-frame instance
module tb_vga_timing_gen;

   localparam int   S_HA = 16, S_HFP = 2, S_HS = 4, S_HBP = 3;
   localparam int   S_VA = 8,  S_VFP = 1, S_VS = 2, S_VBP = 2;
   localparam int   S_HT = S_HA + S_HFP + S_HS + S_HBP;
   localparam int   S_VT = S_VA + S_VFP + S_VS + S_VBP;
   localparam int   S_FRAME = S_HT * S_VT;
   localparam int   S_DIV = 3;
   localparam logic S_HS_POL = 1'b1;
   localparam logic S_VS_POL = 1'b0;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic en0 = 1'b1, restart0 = 1'b0;
   logic en1 = 1'b0, restart1 = 1'b0;

   int chk_cnt = 0;
   int pass_cnt = 0;

   always #5 clk = ~clk;

   vga_timing_gen_if vif0 ();
   vga_timing_gen_if vif1 ();

   vga_timing_gen dut0 (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en0),
      .restart (restart0),
      .vga     (vif0)
   );

   vga_timing_gen #(
      .H_ACTIVE (S_HA), .H_FP (S_HFP), .H_SYNC (S_HS), .H_BP (S_HBP),
      .V_ACTIVE (S_VA), .V_FP (S_VFP), .V_SYNC (S_VS), .V_BP (S_VBP),
      .CLK_DIV  (S_DIV), .HS_POL (S_HS_POL), .VS_POL (S_VS_POL)
   ) dut1 (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en1),
      .restart (restart1),
      .vga     (vif1)
   );

   // Reference for dut1: a phase within the pixel period and a linear pixel index in the frame
   int   m_phase, m_pos, m_x, m_y, m_fcnt;
   logic m_tick, m_fs, m_vo, m_hs, m_vs;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase = 0; m_pos = 0; m_x = 0; m_y = 0; m_fcnt = 0;
         m_tick = 1'b0; m_fs = 1'b0; m_vo = 1'b0; m_hs = ~S_HS_POL; m_vs = ~S_VS_POL;
      end else if (restart1) begin
         m_phase = 0; m_pos = 0; m_x = 0; m_y = 0; m_fcnt = 0;
         m_tick = 1'b1; m_fs = 1'b1; m_vo = 1'b0; m_hs = ~S_HS_POL; m_vs = ~S_VS_POL;
      end else begin
         m_tick = 1'b0;
         m_fs   = 1'b0;
         if (en1) begin
            m_phase = m_phase + 1;
            if (m_phase == S_DIV) begin
               m_phase = 0;
               m_pos   = (m_pos + 1) % S_FRAME;
               m_x     = m_pos % S_HT;
               m_y     = m_pos / S_HT;
               m_tick  = 1'b1;
               m_fs    = (m_pos == 0);
               m_vo    = (m_x < S_HA) && (m_y < S_VA);
               m_hs    = (m_x >= S_HA + S_HFP && m_x < S_HA + S_HFP + S_HS) ? S_HS_POL : ~S_HS_POL;
               m_vs    = (m_y >= S_VA + S_VFP && m_y < S_VA + S_VFP + S_VS) ? S_VS_POL : ~S_VS_POL;
               if (m_pos == 0) m_fcnt = (m_fcnt + 1) % 65536;
            end
         end
      end
   end

   task automatic test_reset();
      repeat (3) @(negedge clk);
      chk_cnt++; if (vif0.x !== 10'd0 || vif0.y !== 10'd0) $display("FAIL reset_xy0: got x=%0d y=%0d, expected 0/0", vif0.x, vif0.y); else pass_cnt++;
      chk_cnt++; if (vif0.hsync !== 1'b1 || vif0.vsync !== 1'b1) $display("FAIL reset_sync0: got hs=%b vs=%b, expected 1/1", vif0.hsync, vif0.vsync); else pass_cnt++;
      chk_cnt++; if (vif0.video_on !== 1'b0 || vif0.pix_tick !== 1'b0 || vif0.frame_start !== 1'b0) $display("FAIL reset_flags0: got vo=%b tick=%b fs=%b, expected 0/0/0", vif0.video_on, vif0.pix_tick, vif0.frame_start); else pass_cnt++;
      chk_cnt++; if (vif1.hsync !== 1'b0 || vif1.vsync !== 1'b1) $display("FAIL reset_sync1: got hs=%b vs=%b, expected 0/1", vif1.hsync, vif1.vsync); else pass_cnt++;
`ifdef VGA_FRAME_CNT_EN
      chk_cnt++; if (vif1.frame_cnt !== 16'd0) $display("FAIL reset_fcnt: got %0d, expected 0", vif1.frame_cnt); else pass_cnt++;
`endif
      rst_n = 1'b1;
   endtask

   task automatic test_line_timing();
      int c = 0, last_tick = -1, bad_gap = 0, starts = 0, c0 = 0, c1 = 0;
      int hs_cnt = 0, hs_first = -1, vo_cnt = 0, first_x = -1, y_start = -1;
      while (starts < 2 && c < 5000) begin
         @(negedge clk);
         c++;
         if (vif0.pix_tick) begin
            if (last_tick >= 0 && c - last_tick != 2) bad_gap++;
            last_tick = c;
            if (first_x < 0) first_x = int'(vif0.x);
            if (vif0.x == 10'd0) begin
               starts++;
               if (starts == 1) begin c0 = c; y_start = int'(vif0.y); end
               else c1 = c;
            end
            if (starts == 1) begin
               if (vif0.hsync == 1'b0) begin
                  hs_cnt++;
                  if (hs_first < 0) hs_first = int'(vif0.x);
               end
               if (vif0.video_on) vo_cnt++;
            end
         end
      end
      chk_cnt++; if (starts != 2) $display("FAIL line_timeout: got %0d line starts, expected 2", starts); else pass_cnt++;
      chk_cnt++; if (first_x != 1) $display("FAIL line_first_x: got %0d, expected 1", first_x); else pass_cnt++;
      chk_cnt++; if (bad_gap != 0) $display("FAIL line_tick_gap: got %0d bad gaps, expected 0", bad_gap); else pass_cnt++;
      chk_cnt++; if (c1 - c0 != 1600) $display("FAIL line_period: got %0d clk, expected 1600", c1 - c0); else pass_cnt++;
      chk_cnt++; if (hs_cnt != 96 || hs_first != 656) $display("FAIL line_hsync: got %0d ticks from x=%0d, expected 96 from 656", hs_cnt, hs_first); else pass_cnt++;
      chk_cnt++; if (vo_cnt != 640) $display("FAIL line_video_on: got %0d, expected 640", vo_cnt); else pass_cnt++;
      chk_cnt++; if (y_start != 1) $display("FAIL line_y: got %0d, expected 1", y_start); else pass_cnt++;
   endtask

   task automatic test_frame_timing();
      int c = 0, fs_seen = 0, ca = 0, cb = 0, vs_cnt = 0, vs_bad = 0, vo_late = 0, vo_cnt = 0, hs_cnt = 0;
      en1 = 1'b1;
      restart1 = 1'b1;
      @(negedge clk);
      restart1 = 1'b0;
      chk_cnt++; if (vif1.pix_tick !== 1'b1 || vif1.frame_start !== 1'b1 || vif1.x !== 10'd0 || vif1.y !== 10'd0 || vif1.video_on !== 1'b0)
         $display("FAIL frame_restart: got tick=%b fs=%b x=%0d y=%0d vo=%b, expected 1 1 0 0 0", vif1.pix_tick, vif1.frame_start, vif1.x, vif1.y, vif1.video_on); else pass_cnt++;
      while (fs_seen < 2 && c < 3000) begin
         @(negedge clk);
         c++;
         if (vif1.pix_tick) begin
            if (vif1.frame_start) begin
               fs_seen++;
               if (fs_seen == 1) ca = c; else cb = c;
            end
            if (fs_seen == 1) begin
               if (vif1.vsync == S_VS_POL) begin
                  vs_cnt++;
                  if (vif1.y < 10'(S_VA + S_VFP) || vif1.y >= 10'(S_VA + S_VFP + S_VS)) vs_bad++;
               end
               if (vif1.video_on) vo_cnt++;
               if (vif1.video_on && vif1.y >= 10'(S_VA)) vo_late++;
               if (vif1.hsync == S_HS_POL) hs_cnt++;
            end
         end
      end
      chk_cnt++; if (cb - ca != S_FRAME * S_DIV) $display("FAIL frame_period: got %0d clk, expected %0d", cb - ca, S_FRAME * S_DIV); else pass_cnt++;
      chk_cnt++; if (vs_cnt != S_VS * S_HT || vs_bad != 0) $display("FAIL frame_vsync: got %0d ticks (%0d misplaced), expected %0d (0)", vs_cnt, vs_bad, S_VS * S_HT); else pass_cnt++;
      chk_cnt++; if (vo_late != 0 || vo_cnt != S_HA * S_VA) $display("FAIL frame_video_on: got %0d (%0d late), expected %0d (0)", vo_cnt, vo_late, S_HA * S_VA); else pass_cnt++;
      chk_cnt++; if (hs_cnt != S_HS * S_VT) $display("FAIL frame_hsync: got %0d, expected %0d", hs_cnt, S_HS * S_VT); else pass_cnt++;
   endtask

   task automatic test_en_freeze();
      int c = 0, bad = 0;
      logic [9:0] hx, hy;
      en1 = 1'b1;
      while (!(vif1.pix_tick && vif1.x == 10'd10 && vif1.y == 10'd3) && c < 2000) begin @(negedge clk); c++; end
      chk_cnt++; if (c >= 2000) $display("FAIL freeze_reach: got timeout, expected x=10 y=3"); else pass_cnt++;
      en1 = 1'b0;
      hx = vif1.x;
      hy = vif1.y;
      repeat (50) begin
         @(negedge clk);
         if (vif1.pix_tick !== 1'b0 || vif1.x !== hx || vif1.y !== hy) bad++;
      end
      chk_cnt++; if (bad != 0) $display("FAIL freeze_hold: got %0d bad cycles, expected 0", bad); else pass_cnt++;
      en1 = 1'b1;
      c = 0;
      do begin @(negedge clk); c++; end while (!vif1.pix_tick && c < 10);
      chk_cnt++; if (vif1.x !== 10'd11 || vif1.y !== 10'd3 || c != S_DIV) $display("FAIL freeze_resume: got x=%0d y=%0d after %0d clk, expected 11 3 after %0d", vif1.x, vif1.y, c, S_DIV); else pass_cnt++;
   endtask

   task automatic test_restart();
      int c = 0, bad = 0;
      en1 = 1'b1;
      while (!(vif1.pix_tick && vif1.x == 10'd20 && vif1.y == 10'd6) && c < 2000) begin @(negedge clk); c++; end
      chk_cnt++; if (c >= 2000 || vif1.hsync !== S_HS_POL) $display("FAIL restart_pre: got hs=%b (timeout=%0b), expected active sync", vif1.hsync, c >= 2000); else pass_cnt++;
      en1 = 1'b0;
      restart1 = 1'b1;
      @(negedge clk);
      restart1 = 1'b0;
      chk_cnt++; if (vif1.x !== 10'd0 || vif1.y !== 10'd0 || vif1.frame_start !== 1'b1 || vif1.pix_tick !== 1'b1 || vif1.hsync !== ~S_HS_POL)
         $display("FAIL restart_out: got x=%0d y=%0d fs=%b tick=%b hs=%b, expected 0 0 1 1 %b", vif1.x, vif1.y, vif1.frame_start, vif1.pix_tick, vif1.hsync, ~S_HS_POL); else pass_cnt++;
      repeat (3) begin
         @(negedge clk);
         if (vif1.pix_tick !== 1'b0 || vif1.frame_start !== 1'b0 || vif1.x !== 10'd0) bad++;
      end
      chk_cnt++; if (bad != 0) $display("FAIL restart_hold: got %0d bad cycles, expected 0", bad); else pass_cnt++;
      en1 = 1'b1;
   endtask

   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         chk_cnt++;
         if (vif1.pix_tick !== m_tick || vif1.frame_start !== m_fs || vif1.x !== 10'(m_x) || vif1.y !== 10'(m_y) ||
             vif1.video_on !== m_vo || vif1.hsync !== m_hs || vif1.vsync !== m_vs)
            $display("FAIL random_cycle%0d: got tick=%b fs=%b x=%0d y=%0d vo=%b hs=%b vs=%b, expected %b %b %0d %0d %b %b %b",
                     i, vif1.pix_tick, vif1.frame_start, vif1.x, vif1.y, vif1.video_on, vif1.hsync, vif1.vsync,
                     m_tick, m_fs, m_x, m_y, m_vo, m_hs, m_vs);
         else pass_cnt++;
`ifdef VGA_FRAME_CNT_EN
         chk_cnt++; if (vif1.frame_cnt !== 16'(m_fcnt)) $display("FAIL random_fcnt%0d: got %0d, expected %0d", i, vif1.frame_cnt, m_fcnt); else pass_cnt++;
`endif
         en1      = ($urandom_range(0, 9) != 0);
         restart1 = ($urandom_range(0, 299) == 0);
      end
      en1 = 1'b1;
      restart1 = 1'b0;
   endtask

   task automatic test_reset_midframe();
      int c = 0;
      while (!(vif1.pix_tick && vif1.y == 10'd4 && vif1.x == 10'd5) && c < 2000) begin @(negedge clk); c++; end
      chk_cnt++; if (c >= 2000) $display("FAIL midreset_reach: got timeout, expected y=4"); else pass_cnt++;
      rst_n = 1'b0;
      #1;
      chk_cnt++; if (vif1.x !== 10'd0 || vif1.y !== 10'd0 || vif1.hsync !== ~S_HS_POL || vif1.vsync !== ~S_VS_POL || vif1.pix_tick !== 1'b0)
         $display("FAIL midreset_async: got x=%0d y=%0d hs=%b vs=%b tick=%b, expected 0 0 %b %b 0", vif1.x, vif1.y, vif1.hsync, vif1.vsync, vif1.pix_tick, ~S_HS_POL, ~S_VS_POL); else pass_cnt++;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      c = 0;
      do begin @(negedge clk); c++; end while (!vif1.pix_tick && c < 10);
      chk_cnt++; if (vif1.x !== 10'd1 || vif1.y !== 10'd0 || c != S_DIV) $display("FAIL midreset_first: got x=%0d y=%0d after %0d clk, expected 1 0 after %0d", vif1.x, vif1.y, c, S_DIV); else pass_cnt++;
   endtask

`ifdef VGA_FRAME_CNT_EN
   task automatic test_frame_cnt();
      int c = 0, fs = 0;
      en1 = 1'b1;
      restart1 = 1'b1;
      @(negedge clk);
      restart1 = 1'b0;
      while (fs < 3 && c < 4000) begin
         @(negedge clk);
         c++;
         if (vif1.frame_start) fs++;
      end
      chk_cnt++; if (vif1.frame_cnt !== 16'd3) $display("FAIL fcnt_three: got %0d, expected 3", vif1.frame_cnt); else pass_cnt++;
      restart1 = 1'b1;
      @(negedge clk);
      restart1 = 1'b0;
      chk_cnt++; if (vif1.frame_cnt !== 16'd0) $display("FAIL fcnt_restart: got %0d, expected 0", vif1.frame_cnt); else pass_cnt++;
      force dut1.frame_cnt_q = 16'hFFFF;
      #1;
      release dut1.frame_cnt_q;
      c = 0;
      do begin @(negedge clk); c++; end while (!vif1.frame_start && c < 2000);
      chk_cnt++; if (vif1.frame_cnt !== 16'd0) $display("FAIL fcnt_wrap: got %0d, expected 0", vif1.frame_cnt); else pass_cnt++;
   endtask
`endif

   initial begin
      test_reset();
      test_line_timing();
      test_frame_timing();
      test_en_freeze();
      test_restart();
      test_random();
      test_reset_midframe();
`ifdef VGA_FRAME_CNT_EN
      test_frame_cnt();
`endif
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
